// File: rtl/shift_load_ctrl.sv
// Sequencer that serially loads a parallel word into an external bidirectional shift register.
// Optional feature macro: SHIFT_CTRL_SHADOW_EN adds shadow_q, an internal model of the register contents.
module shift_load_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             shift_left,
  output logic             shift_right,
  output logic             serial_in,
  output logic             busy,
  output logic             done
`ifdef SHIFT_CTRL_SHADOW_EN
  ,
  output logic [WIDTH-1:0] shadow_q
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             dir_reg, dir_next;
  logic             shift_left_reg, shift_left_next;
  logic             shift_right_reg, shift_right_next;
  logic             serial_in_reg, serial_in_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      data_reg        <= '0;
      dir_reg         <= 1'b0;
      shift_left_reg  <= 1'b0;
      shift_right_reg <= 1'b0;
      serial_in_reg   <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      data_reg        <= data_next;
      dir_reg         <= dir_next;
      shift_left_reg  <= shift_left_next;
      shift_right_reg <= shift_right_next;
      serial_in_reg   <= serial_in_next;
      done_reg        <= done_next;
    end
  end

  // The latched word is consumed as it is sent: the next bit to emit always
  // sits at the MSB (left loads) or LSB (right loads) of data_reg.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    data_next        = data_reg;
    dir_next         = dir_reg;
    shift_left_next  = 1'b0;
    shift_right_next = 1'b0;
    serial_in_next   = 1'b0;
    done_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next       = SHIFT;
          cnt_next         = '0;
          dir_next         = in_dir;
          shift_left_next  = ~in_dir;
          shift_right_next = in_dir;
          if (in_dir) begin
            serial_in_next = in_data[0];
            data_next      = {1'b0, in_data[WIDTH-1:1]};
          end else begin
            serial_in_next = in_data[WIDTH-1];
            data_next      = {in_data[WIDTH-2:0], 1'b0};
          end
        end
      end

      SHIFT: begin
        if (cnt_reg == LAST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          cnt_next         = cnt_reg + 1'b1;
          shift_left_next  = ~dir_reg;
          shift_right_next = dir_reg;
          if (dir_reg) begin
            serial_in_next = data_reg[0];
            data_next      = {1'b0, data_reg[WIDTH-1:1]};
          end else begin
            serial_in_next = data_reg[WIDTH-1];
            data_next      = {data_reg[WIDTH-2:0], 1'b0};
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg == SHIFT) || (state_reg == DONE);
  assign shift_left  = shift_left_reg;
  assign shift_right = shift_right_reg;
  assign serial_in   = serial_in_reg;
  assign done        = done_reg;

`ifdef SHIFT_CTRL_SHADOW_EN
  logic [WIDTH-1:0] shadow_reg;

  // Tracks the external register edge for edge from the same registered controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_reg <= '0;
    end else if (shift_left_reg) begin
      shadow_reg <= {shadow_reg[WIDTH-2:0], serial_in_reg};
    end else if (shift_right_reg) begin
      shadow_reg <= {serial_in_reg, shadow_reg[WIDTH-1:1]};
    end
  end

  assign shadow_q = shadow_reg;
`endif

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Scoreboard bench for shift_load_ctrl: stimulus queues expected control bits and words,
// a negedge monitor checks them as the DUT drives the attached register model.
module tb_shift_load_ctrl;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_dir = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, shift_left, shift_right, serial_in, busy, done;
`ifdef SHIFT_CTRL_SHADOW_EN
  logic [7:0] shadow_q;
`endif

  shift_load_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dir(in_dir),
    .shift_left(shift_left),
    .shift_right(shift_right),
    .serial_in(serial_in),
    .busy(busy),
    .done(done)
`ifdef SHIFT_CTRL_SHADOW_EN
    ,
    .shadow_q(shadow_q)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [2:0] ctrl_q[$];
  logic [7:0] word_q[$];
  int acc_q[$];
  int acc_log[$];
  logic [7:0] ext_reg = 8'h00;
  logic ext_clr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Attached external shift register; never reset by the DUT.
  always @(posedge clk) begin
    if (ext_clr) ext_reg <= 8'h00;
    else if (shift_left) ext_reg <= {ext_reg[6:0], serial_in};
    else if (shift_right) ext_reg <= {serial_in, ext_reg[7:1]};
  end

  // Monitor: acceptance log, per-cycle control check, word check on done.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      acc_q.push_back(cyc + 1);
      acc_log.push_back(cyc + 1);
    end
    if (shift_left || shift_right) begin
      if (ctrl_q.size() == 0) check("ctrl_unexpected", {shift_left, shift_right, serial_in}, 0);
      else check("ctrl", {shift_left, shift_right, serial_in}, ctrl_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      if (word_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        logic [7:0] w;
        w = word_q.pop_front();
        check("ext_reg_at_done", ext_reg, w);
`ifdef SHIFT_CTRL_SHADOW_EN
        check("shadow_at_done", shadow_q, w);
`endif
        if (acc_q.size() == 0) check("done_without_accept", 1, 0);
        else check("done_latency", cyc - acc_q.pop_front(), WIDTH);
      end
      $display("txn done word=%02h ext=%02h cycle=%0d", ext_reg, ext_reg, cyc);
    end
  end

  // seq holds the expected serial_in bits in transmission order, first bit at [7].
  task automatic load(input logic [7:0] d, input logic dir, input logic [7:0] seq,
                      input int nbits, input logic [7:0] after_data, input logic after_valid);
    bit ok;
    for (int k = 0; k < nbits; k++) ctrl_q.push_back({~dir, dir, seq[7-k]});
    if (nbits == 8) word_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_data  = after_data;
    in_valid = after_valid;
    $display("txn issue data=%02h dir=%0d", d, dir);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ctrl_q.size() == 0 && word_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int d0;
    // Reset held for two edges with a pending request: nothing may be accepted.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ctrl", {shift_left, shift_right, serial_in}, 0);
`ifdef SHIFT_CTRL_SHADOW_EN
    check("rst_shadow", shadow_q, 0);
`endif
    check("rst_no_accept", acc_log.size(), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Left load 0xA5: MSB first.
    load(8'hA5, 1'b0, 8'b1010_0101, 8, 8'h00, 1'b0);
    wait_idle();
    check("ext_after_a5", ext_reg, 8'hA5);

    // Right load 0x3C: LSB first gives 0,0,1,1,1,1,0,0.
    load(8'h3C, 1'b1, 8'b0011_1100, 8, 8'h00, 1'b0);
    wait_idle();

    // Busy rejection: 0xFF held valid through the 0x81 load.
    load(8'h81, 1'b0, 8'b1000_0001, 8, 8'hFF, 1'b1);
    load(8'hFF, 1'b0, 8'b1111_1111, 8, 8'h00, 1'b0);
    wait_idle();
    check("accept_gap", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 10);

    // Handshake: data changes right after acceptance must not leak in.
    load(8'h5A, 1'b0, 8'b0101_1010, 8, 8'h00, 1'b0);
    wait_idle();
    check("ext_after_5a", ext_reg, 8'h5A);

    // Reset during the load of 0xF0 so the register sees exactly four shifts.
    @(negedge clk) ext_clr = 1'b1;
    @(negedge clk) ext_clr = 1'b0;
    d0 = done_cnt;
    load(8'hF0, 1'b0, 8'b1111_0000, 4, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ctrl", {shift_left, shift_right, serial_in}, 0);
    check("midrst_ext", ext_reg, 8'h0F);
`ifdef SHIFT_CTRL_SHADOW_EN
    check("midrst_shadow", shadow_q, 0);
`endif
    acc_q.delete();
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_ext_hold", ext_reg, 8'h0F);
    check("midrst_ctrl_left", ctrl_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
